// File: rtl/score_plotter_if.sv
// score_plotter_if: start/score request, renderer handshake and VGA write bundle.
// slave = the plotter's view; master = the surrounding game control / renderer / VGA side.
interface score_plotter_if;
    logic        start;
    logic [9:0]  score;
    logic [3:0]  scale;
    logic        busy;
    logic        done;
    logic        rend_draw_en;
    logic        rend_ld_en;
    logic        rend_pause;
    logic [9:0]  rend_score;
    logic        rend_done;
    logic [5:0]  rend_offset;
    logic [1:0]  rend_digit_offset;
    logic [63:0] rend_bitarray;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    modport slave (
        input  start, score, scale, rend_done, rend_offset, rend_digit_offset, rend_bitarray,
        output busy, done, rend_draw_en, rend_ld_en, rend_pause, rend_score, x, y, colour, plot
    );

    modport master (
        output start, score, scale, rend_done, rend_offset, rend_digit_offset, rend_bitarray,
        input  busy, done, rend_draw_en, rend_ld_en, rend_pause, rend_score, x, y, colour, plot
    );
endinterface

// File: rtl/score_plotter.sv
// score_plotter: drives the digit renderer and expands each glyph bit into a scale x scale block of VGA writes.
// Optional macro SCORE_PLOTTER_TRANSPARENT_EN: clear glyph bits are skipped (plot = 0) instead of painted BG_COLOUR.
module score_plotter #(
    parameter logic [7:0] X_ORIGIN    = 8'd4,
    parameter logic [6:0] Y_ORIGIN    = 7'd4,
    parameter logic [3:0] DIGIT_PITCH = 4'd10,
    parameter logic [2:0] FG_COLOUR   = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic           clk,
    input  logic           resetn,
    score_plotter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_DRAW      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FIN       = 3'd4
    } state_t;

    function automatic logic [3:0] f_norm_scale(input logic [3:0] s);
        case (s)
            4'd1, 4'd2, 4'd4, 4'd8: f_norm_scale = s;
            default:               f_norm_scale = 4'd1;
        endcase
    endfunction

    function automatic logic [1:0] f_digit_count(input logic [9:0] v);
        if (v > 10'd99) begin
            f_digit_count = 2'd3;
        end else if (v > 10'd9) begin
            f_digit_count = 2'd2;
        end else begin
            f_digit_count = 2'd1;
        end
    endfunction

    state_t      r_state;
    state_t      w_state_nx;
    logic [9:0]  r_score;
    logic [3:0]  r_scale;
    logic [1:0]  r_ndig;
    logic [2:0]  r_sx;
    logic [2:0]  r_sy;
    logic [2:0]  w_sx_nx;
    logic [2:0]  w_sy_nx;
    logic [2:0]  w_smax;
    logic        r_draw_en;
    logic        r_ld_en;
    logic        r_pause;
    logic        r_busy;
    logic        r_done;
    logic        w_draw_en_nx;
    logic        w_ld_en_nx;
    logic        w_pause_nx;
    logic        w_busy_nx;
    logic        w_done_nx;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_plot;
    logic        w_sub_last;
    logic        w_glyph_last;
    logic        w_pix_bit;
    logic [2:0]  w_row;
    logic [2:0]  w_col;
    logic [7:0]  w_x;
    logic [6:0]  w_y;

    assign w_smax       = 3'(r_scale - 4'd1);
    assign w_row        = bus.rend_offset[5:3];
    assign w_col        = bus.rend_offset[2:0];
    assign w_sub_last   = (r_sx == w_smax) && (r_sy == w_smax);
    assign w_glyph_last = (bus.rend_offset == 6'd63) && (bus.rend_digit_offset == (r_ndig - 2'd1));
    assign w_pix_bit    = bus.rend_bitarray[6'd63 - bus.rend_offset];

    // Pixel position is formed in 9 bits; the maximum fits the port widths, so truncation is lossless.
    assign w_x = 8'(9'(X_ORIGIN) + 9'(bus.rend_digit_offset) * 9'(DIGIT_PITCH) * 9'(r_scale)
                    + 9'(w_col) * 9'(r_scale) + 9'(r_sx));
    assign w_y = 7'(9'(Y_ORIGIN) + 9'(w_row) * 9'(r_scale) + 9'(r_sy));

    // Sub-pixel counters: sx steps first, sy advances when sx wraps.
    always_comb begin
        w_sx_nx = 3'd0;
        w_sy_nx = 3'd0;
        if (r_state == S_DRAW) begin
            if (r_sx == w_smax) begin
                w_sx_nx = 3'd0;
                if (r_sy == w_smax) begin
                    w_sy_nx = 3'd0;
                end else begin
                    w_sy_nx = r_sy + 3'd1;
                end
            end else begin
                w_sx_nx = r_sx + 3'd1;
                w_sy_nx = r_sy;
            end
        end else begin
            w_sx_nx = 3'd0;
            w_sy_nx = 3'd0;
        end
    end

    // Next state, and renderer controls decoded from it so they can be registered.
    always_comb begin
        w_state_nx   = r_state;
        w_draw_en_nx = 1'b0;
        w_ld_en_nx   = 1'b0;
        w_pause_nx   = 1'b0;
        w_busy_nx    = 1'b0;
        w_done_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_LOAD;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_LOAD:      w_state_nx = S_DRAW;
            S_DRAW: begin
                if (w_sub_last && w_glyph_last) begin
                    w_state_nx = S_WAIT_DONE;
                end else begin
                    w_state_nx = S_DRAW;
                end
            end
            S_WAIT_DONE: begin
                if (bus.rend_done) begin
                    w_state_nx = S_FIN;
                end else begin
                    w_state_nx = S_WAIT_DONE;
                end
            end
            S_FIN:       w_state_nx = S_IDLE;
            default:     w_state_nx = S_IDLE;
        endcase

        case (w_state_nx)
            S_LOAD: begin
                w_draw_en_nx = 1'b1;
                w_ld_en_nx   = 1'b1;
                w_pause_nx   = 1'b1;
                w_busy_nx    = 1'b1;
            end
            S_DRAW: begin
                w_draw_en_nx = 1'b1;
                w_pause_nx   = !((w_sx_nx == w_smax) && (w_sy_nx == w_smax));
                w_busy_nx    = 1'b1;
            end
            S_WAIT_DONE: begin
                w_draw_en_nx = 1'b1;
                w_busy_nx    = 1'b1;
            end
            S_FIN: begin
                w_done_nx = 1'b1;
                w_busy_nx = 1'b1;
            end
            default: begin
                w_draw_en_nx = 1'b0;
                w_busy_nx    = 1'b0;
            end
        endcase
    end

    // State, counters, latched request and registered control outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_sx      <= 3'd0;
            r_sy      <= 3'd0;
            r_score   <= 10'd0;
            r_scale   <= 4'd0;
            r_ndig    <= 2'd0;
            r_draw_en <= 1'b0;
            r_ld_en   <= 1'b0;
            r_pause   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sx      <= w_sx_nx;
            r_sy      <= w_sy_nx;
            r_draw_en <= w_draw_en_nx;
            r_ld_en   <= w_ld_en_nx;
            r_pause   <= w_pause_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            if ((r_state == S_IDLE) && bus.start) begin
                r_score <= bus.score;
                r_scale <= f_norm_scale(bus.scale);
                r_ndig  <= f_digit_count(bus.score);
            end
        end
    end

    // VGA write register: one pixel per DRAW cycle, visible the following cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
        end else if (r_state == S_DRAW) begin
            r_x      <= w_x;
            r_y      <= w_y;
            r_colour <= w_pix_bit ? FG_COLOUR : BG_COLOUR;
`ifdef SCORE_PLOTTER_TRANSPARENT_EN
            r_plot   <= w_pix_bit;
`else
            r_plot   <= 1'b1;
`endif
        end else begin
            r_plot   <= 1'b0;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.rend_draw_en = r_draw_en;
    assign bus.rend_ld_en   = r_ld_en;
    assign bus.rend_pause   = r_pause;
    assign bus.rend_score   = r_score;
    assign bus.x            = r_x;
    assign bus.y            = r_y;
    assign bus.colour       = r_colour;
    assign bus.plot         = r_plot;

endmodule

// File: doc/score_plotter.md
# score_plotter

Sequential pixel plotter that drives the digit renderer and converts its glyph stream into VGA adapter writes. On a `start` pulse it latches a 0–999 score and a scale factor, then runs the renderer's `draw_en`/`ld_en`/`pause` handshake. It expands each 8×8 glyph bit into a scale×scale block of `x`/`y`/`colour`/`plot` writes and signals `done` when the last digit is on screen. It sits between game control and the VGA adapter, next to the renderer.

## Interface
- `X_ORIGIN`, 8'd4: screen x of the top-left of the leftmost digit.
- `Y_ORIGIN`, 7'd4: screen y of the top row.
- `DIGIT_PITCH`, 4'd10: horizontal digit spacing in glyph pixels, multiplied by scale.
- `FG_COLOUR`, 3'b111: colour for set glyph bits.
- `BG_COLOUR`, 3'b000: colour for clear glyph bits.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to render; sampled only in IDLE.
- `score`  in  10  value to render, 0–999; sampled with `start`.
- `scale`  in  4  pixel scale (1, 2, 4 or 8); sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rend_draw_en`  out  1  renderer draw enable; low resets the renderer.
- `rend_ld_en`  out  1  renderer score load.
- `rend_pause`  out  1  renderer hold; low advances the glyph offset by one.
- `rend_score`  out  10  latched score, fed to the renderer.
- `rend_done`  in  1  renderer finished flag.
- `rend_offset`  in  6  glyph pixel index; row = [5:3], col = [2:0].
- `rend_digit_offset`  in  2  digit index from the left.
- `rend_bitarray`  in  64  current glyph; bit (63 − offset) is the pixel.
- `x`  out  8  VGA x.
- `y`  out  7  VGA y.
- `colour`  out  3  VGA colour.
- `plot`  out  1  VGA write enable.

## Operation
- FSM states: IDLE → LOAD → DRAW → WAIT_DONE → FIN → IDLE.
- IDLE: all renderer controls low. `start` high latches `score` and `scale`, computes the digit count N and moves to LOAD.
  - N = 3 if score > 99; N = 2 if score > 9; otherwise N = 1.
  - Any scale value other than 1, 2, 4 or 8 is latched as 1.
- LOAD (exactly one cycle): `rend_draw_en` = 1, `rend_ld_en` = 1, `rend_pause` = 1.
- DRAW: `rend_draw_en` = 1 and `rend_ld_en` = 0.
  - Sub-pixel counters `sx` and `sy` (3 bits each, range 0..s−1) step `sx` first, then `sy`.
  - `rend_pause` = 0 only on the cycle where `sx` = `sy` = s−1. The counters wrap to 0 on that cycle.
  - Leave DRAW after that cycle at `rend_offset` = 63, `rend_digit_offset` = N−1.
- WAIT_DONE: `rend_draw_en` = 1 and `rend_pause` = 0. Stay until `rend_done` is sampled high.
- FIN (one cycle): `done` = 1 and `rend_draw_en` = 0, which resets the renderer. Then return to IDLE.
- Pixel arithmetic, computed in 9 bits and truncated to the port widths:
  - x = X_ORIGIN + digit·DIGIT_PITCH·s + col·s + sx.
  - y = Y_ORIGIN + row·s + sy.
  - Maximum with default parameters: x = 227, y = 67. No overflow.
- Each DRAW cycle plots exactly one pixel.
  - `colour` = FG_COLOUR if the glyph bit is set, otherwise BG_COLOUR.
  - `plot` = 1 for both cases, so background is overwritten and any previous score is erased.
- `start` is ignored while busy. `score` and `scale` changes after sampling have no effect.

## Timing
- Reset values: `x` = 0, `y` = 0, `colour` = 0, `plot` = 0, `done` = 0, `busy` = 0, all `rend_*` outputs = 0, FSM in IDLE, counters at 0.
- Reset asserted mid-operation returns to IDLE immediately. `rend_draw_en` drops, so the renderer clears on its next clock.
- `x`, `y`, `colour` and `plot` are registered: one-cycle latency from the DRAW cycle that produced them. The final plot is visible in the first WAIT_DONE cycle.
- DRAW lasts exactly N·64·s² cycles.
- `done` rises no earlier than two cycles after the final plot and is high for exactly one cycle.
- `busy` rises the cycle after `start` is accepted and falls together with the FIN→IDLE transition.
- A new `start` can be accepted in the first IDLE cycle after FIN.

## Configuration
- `SCORE_PLOTTER_TRANSPARENT_EN` defined: clear glyph bits give `plot` = 0, and BG_COLOUR is never written. DRAW cycle count is unchanged; `x`/`y` still advance.
- Macro undefined: every glyph pixel is plotted, with background in BG_COLOUR (default behaviour above).

## Test plan
- score = 7, s = 1, macro off → 64 plots, x 4..11, y 4..11; `colour` matches the "7" glyph bit pattern; one `done` pulse.
- score = 123, s = 2 → 768 plots; digit 2 top-left pixel at x = 44, y = 4; renderer `rend_done` observed before `done`.
- score = 0, s = 8 → 4096 plots spanning x 4..67, y 4..67; `busy` high throughout.
- s = 3 (invalid) and `start` re-pulsed while busy → behaves as s = 1; the second `start` is ignored; exactly one `done`.
- `resetn` low during DRAW of score 45 → all outputs 0 within the same cycle, FSM in IDLE; a fresh `start` renders correctly.
- `SCORE_PLOTTER_TRANSPARENT_EN` defined, score = 1, s = 1 → `plot` count equals the number of set bits in the "1" glyph; total DRAW length still 64 cycles.
